snake_body_engine: RTL and testbench

Parametrised snake body engine that replaces the fixed 15-segment shift chain with a circular segment buffer of configurable depth and grid size. It runs on the pixel clock with a single-cycle `STEP` enable instead of a second clock. It rejects 180° reversals, grows on apple hits, and detects self-collision with a serial scan FSM. It sits between the navigation/master-state logic and the VGA colour mux, and returns per-pixel head/body flags and game events.

---
 rtl/snake_pkg.sv | 44 ++++
 rtl/snake_next_head.sv | 73 +++++++
 rtl/snake_body_engine.sv | 274 +++++++++++++++++++++++++++
 tb/tb_snake_body_engine.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake body engine.
//   dir_t   : movement direction as encoded on the DIR input.
//   state_t : step sequencer states.
//   cell_t  : grid cell {x, y}, wide enough for any cell addressed by ADDRH/ADDRV.
//   opposite(): the 180-degree reverse of a direction.
//   ring_sub(): (a - b) mod n for indices already inside [0, n).
package snake_pkg;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    DOWN  = 2'd1,
    UP    = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    StIdle,
    StMove,
    StScan,
    StDone
  } state_t;

  localparam int unsigned CellXW = 10;
  localparam int unsigned CellYW = 9;

  typedef struct packed {
    logic [CellXW-1:0] x;
    logic [CellYW-1:0] y;
  } cell_t;

  function automatic dir_t opposite(dir_t d);
    case (d)
      RIGHT:   return LEFT;
      LEFT:    return RIGHT;
      UP:      return DOWN;
      default: return UP;
    endcase
  endfunction

  function automatic int unsigned ring_sub(int unsigned a, int unsigned b, int unsigned n);
    return (a >= b) ? (a - b) : (a + n - b);
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculator.
// Ports:
//   cur_x_i/cur_y_i   : current head cell.
//   dir_i             : direction of travel (dir_t encoding).
//   next_x_o/next_y_o : cell the head moves into.
//   out_of_grid_o     : the move leaves the grid (never set when wrapping).
// Build option: define SNAKE_WRAP_EN to wrap around the grid edges instead of hitting a wall.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W = 80,
  parameter int unsigned GRID_H = 60
) (
  input  logic [CellXW-1:0] cur_x_i,
  input  logic [CellYW-1:0] cur_y_i,
  input  logic [1:0]        dir_i,
  output logic [CellXW-1:0] next_x_o,
  output logic [CellYW-1:0] next_y_o,
  output logic              out_of_grid_o
);

`ifdef SNAKE_WRAP_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  localparam logic [CellXW-1:0] XMax = CellXW'(GRID_W - 1);
  localparam logic [CellYW-1:0] YMax = CellYW'(GRID_H - 1);

  // In wall mode an out-of-grid move leaves next_* at the current head; the caller
  // discards it anyway.
  always_comb begin
    next_x_o      = cur_x_i;
    next_y_o      = cur_y_i;
    out_of_grid_o = 1'b0;
    case (dir_t'(dir_i))
      RIGHT: begin
        if (cur_x_i == XMax) begin
          if (WrapEn) next_x_o = '0;
          else        out_of_grid_o = 1'b1;
        end else begin
          next_x_o = cur_x_i + CellXW'(1);
        end
      end
      LEFT: begin
        if (cur_x_i == '0) begin
          if (WrapEn) next_x_o = XMax;
          else        out_of_grid_o = 1'b1;
        end else begin
          next_x_o = cur_x_i - CellXW'(1);
        end
      end
      DOWN: begin
        if (cur_y_i == YMax) begin
          if (WrapEn) next_y_o = '0;
          else        out_of_grid_o = 1'b1;
        end else begin
          next_y_o = cur_y_i + CellYW'(1);
        end
      end
      default: begin
        if (cur_y_i == '0) begin
          if (WrapEn) next_y_o = YMax;
          else        out_of_grid_o = 1'b1;
        end else begin
          next_y_o = cur_y_i - CellYW'(1);
        end
      end
    endcase
  end

endmodule

// File: rtl/snake_body_engine.sv
// Snake body engine: circular segment buffer, step sequencer with serial self-collision
// scan, apple growth and per-pixel head/body rendering, all on the pixel clock.
// Ports:
//   CLK, RESETN          : pixel clock, async active-low reset (release synchronised here).
//   START                : synchronous restart, same effect as reset.
//   STEP, DIR            : game tick and requested direction.
//   APPLE_X/APPLE_Y      : apple cell.
//   ADDRH/ADDRV          : pixel being drawn; PIX_HEAD/PIX_BODY follow one cycle later.
//   HEAD_X/HEAD_Y/LENGTH : snake state.
//   BUSY, STEP_DONE, HIT_APPLE : step progress and events.
//   SUICIDE, WALL_HIT, ALIVE   : sticky game-over status.
// Build option: SNAKE_WRAP_EN makes the grid toroidal and ties WALL_HIT low.
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W     = 80,
  parameter int unsigned GRID_H     = 60,
  parameter int unsigned MAX_LEN    = 32,
  parameter int unsigned INIT_LEN   = 5,
  parameter int unsigned INIT_X     = 16,
  parameter int unsigned INIT_Y     = 30,
  parameter int unsigned CELL_SHIFT = 3,
  localparam int unsigned X_W       = $clog2(GRID_W),
  localparam int unsigned Y_W       = $clog2(GRID_H),
  localparam int unsigned LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             START,
  input  logic             STEP,
  input  logic [1:0]       DIR,
  input  logic [X_W-1:0]   APPLE_X,
  input  logic [Y_W-1:0]   APPLE_Y,
  input  logic [9:0]       ADDRH,
  input  logic [8:0]       ADDRV,
  output logic             PIX_HEAD,
  output logic             PIX_BODY,
  output logic [X_W-1:0]   HEAD_X,
  output logic [Y_W-1:0]   HEAD_Y,
  output logic [LEN_W-1:0] LENGTH,
  output logic             BUSY,
  output logic             STEP_DONE,
  output logic             HIT_APPLE,
  output logic             SUICIDE,
  output logic             WALL_HIT,
  output logic             ALIVE
);

  localparam int unsigned PtrW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [PtrW-1:0]  HpInit  = PtrW'(INIT_LEN - 1);
  localparam logic [LEN_W-1:0] LenInit = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0] LenMax  = LEN_W'(MAX_LEN);

  // Initial body: head at the highest initial slot, body trailing upwards.
  function automatic cell_t init_seg(int unsigned k);
    cell_t c;
    c = '0;
    if (k < INIT_LEN) begin
      c.x = CellXW'(INIT_X);
      c.y = CellYW'(INIT_Y + k + 1 - INIT_LEN);
    end
    return c;
  endfunction

  // Assert asynchronously, release two clocks later.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_t            state_q, state_d;
  logic [PtrW-1:0]   hp_q, hp_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  dir_t              dir_q, dir_d;
  logic              grow_q, grow_d;
  logic              suicide_q, suicide_d;
  logic              wall_q, wall_d;
  cell_t             nxt_q, nxt_d;
  logic              oog_q, oog_d;
  logic              pix_head_q, pix_head_d;
  logic              pix_body_q, pix_body_d;

  cell_t             seg_q [MAX_LEN];
  logic              seg_we;
  logic [PtrW-1:0]   hp_inc;

  cell_t             head;
  cell_t             scan_seg;
  cell_t             apple;
  cell_t             nh;
  logic              nh_oog;
  dir_t              dir_req;
  dir_t              dir_eff;
  logic              alive;
  logic              apple_hit;

  assign head     = seg_q[hp_q];
  assign scan_seg = seg_q[PtrW'(ring_sub(32'(hp_q), 32'(idx_q), MAX_LEN))];
  assign apple    = '{x: CellXW'(APPLE_X), y: CellYW'(APPLE_Y)};
  assign alive    = !(suicide_q || wall_q);
  assign hp_inc   = (hp_q == PtrW'(MAX_LEN - 1)) ? '0 : hp_q + PtrW'(1);

  // A reversal request keeps the current heading.
  assign dir_req = dir_t'(DIR);
  assign dir_eff = (dir_req == opposite(dir_q)) ? dir_q : dir_req;

  snake_next_head #(
    .GRID_W(GRID_W),
    .GRID_H(GRID_H)
  ) u_next_head (
    .cur_x_i       (head.x),
    .cur_y_i       (head.y),
    .dir_i         (dir_eff),
    .next_x_o      (nh.x),
    .next_y_o      (nh.y),
    .out_of_grid_o (nh_oog)
  );

  // Collision flags are sticky, so either being set in DONE means this step collided.
  assign apple_hit = (state_q == StDone) && alive && (head == apple);

  always_comb begin
    state_d   = state_q;
    hp_d      = hp_q;
    len_d     = len_q;
    idx_d     = idx_q;
    dir_d     = dir_q;
    grow_d    = grow_q;
    suicide_d = suicide_q;
    wall_d    = wall_q;
    nxt_d     = nxt_q;
    oog_d     = oog_q;
    seg_we    = 1'b0;

    case (state_q)
      StIdle: begin
        if (STEP && alive) begin
          dir_d   = dir_eff;
          nxt_d   = nh;
          oog_d   = nh_oog;
          state_d = StMove;
        end
      end
      StMove: begin
        grow_d = 1'b0;
        if (oog_q) begin
          wall_d  = 1'b1;
          state_d = StDone;
        end else begin
          hp_d   = hp_inc;
          seg_we = 1'b1;
          if (grow_q && (len_q < LenMax)) len_d = len_q + LEN_W'(1);
          idx_d   = LEN_W'(1);
          state_d = StScan;
        end
      end
      StScan: begin
        if (head == scan_seg) begin
          suicide_d = 1'b1;
          state_d   = StDone;
        end else if (idx_q == len_q - LEN_W'(1)) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + LEN_W'(1);
        end
      end
      StDone: begin
        if (apple_hit) grow_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (START) begin
      state_d   = StIdle;
      hp_d      = HpInit;
      len_d     = LenInit;
      idx_d     = '0;
      dir_d     = DOWN;
      grow_d    = 1'b0;
      suicide_d = 1'b0;
      wall_d    = 1'b0;
      nxt_d     = '0;
      oog_d     = 1'b0;
      seg_we    = 1'b0;
    end
  end

  // Render: every buffer slot is compared against the pixel's cell in parallel.
  logic [9:0] cx;
  logic [8:0] cy;
  assign cx = ADDRH >> CELL_SHIFT;
  assign cy = ADDRV >> CELL_SHIFT;

  always_comb begin
    logic        in_grid;
    logic        head_px;
    logic        body_px;
    int unsigned off;
    in_grid = (32'(cx) < GRID_W) && (32'(cy) < GRID_H);
    head_px = (cx == head.x) && (cy == head.y);
    body_px = 1'b0;
    off     = 0;
    for (int unsigned k = 0; k < MAX_LEN; k++) begin
      off = ring_sub(32'(hp_q), k, MAX_LEN);
      if ((off >= 1) && (off < 32'(len_q)) && (seg_q[k].x == cx) && (seg_q[k].y == cy)) begin
        body_px = 1'b1;
      end
    end
    pix_head_d = in_grid && head_px && !START;
    pix_body_d = in_grid && body_px && !head_px && !START;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hp_q       <= HpInit;
      len_q      <= LenInit;
      idx_q      <= '0;
      dir_q      <= DOWN;
      grow_q     <= 1'b0;
      suicide_q  <= 1'b0;
      wall_q     <= 1'b0;
      nxt_q      <= '0;
      oog_q      <= 1'b0;
      pix_head_q <= 1'b0;
      pix_body_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hp_q       <= hp_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      dir_q      <= dir_d;
      grow_q     <= grow_d;
      suicide_q  <= suicide_d;
      wall_q     <= wall_d;
      nxt_q      <= nxt_d;
      oog_q      <= oog_d;
      pix_head_q <= pix_head_d;
      pix_body_q <= pix_body_d;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < MAX_LEN; k++) seg_q[k] <= init_seg(k);
    end else if (START) begin
      for (int unsigned k = 0; k < MAX_LEN; k++) seg_q[k] <= init_seg(k);
    end else if (seg_we) begin
      seg_q[hp_inc] <= nxt_q;
    end
  end

  assign PIX_HEAD  = pix_head_q;
  assign PIX_BODY  = pix_body_q;
  assign HEAD_X    = head.x[X_W-1:0];
  assign HEAD_Y    = head.y[Y_W-1:0];
  assign LENGTH    = len_q;
  assign BUSY      = (state_q != StIdle);
  assign STEP_DONE = (state_q == StDone);
  assign HIT_APPLE = apple_hit;
  assign SUICIDE   = suicide_q;
  assign ALIVE     = alive;
`ifdef SNAKE_WRAP_EN
  assign WALL_HIT  = 1'b0;
`else
  assign WALL_HIT  = wall_q;
`endif

endmodule

// File: tb/tb_snake_body_engine.sv
module tb_snake_body_engine;

  localparam int GW = 80;
  localparam int GH = 60;
  localparam int ML = 6;
  localparam int CS = 3;
  localparam int XW = $clog2(GW);
  localparam int YW = $clog2(GH);
  localparam int LW = $clog2(ML + 1);

  logic          CLK = 1'b0;
  logic          RESETN = 1'b0;
  logic          START = 1'b0;
  logic          STEP = 1'b0;
  logic [1:0]    DIR = 2'd1;
  logic [XW-1:0] APPLE_X = '0;
  logic [YW-1:0] APPLE_Y = '0;
  logic [9:0]    ADDRH = '0;
  logic [8:0]    ADDRV = '0;
  logic          PIX_HEAD, PIX_BODY;
  logic [XW-1:0] HEAD_X;
  logic [YW-1:0] HEAD_Y;
  logic [LW-1:0] LENGTH;
  logic          BUSY, STEP_DONE, HIT_APPLE, SUICIDE, WALL_HIT, ALIVE;

  snake_body_engine #(
    .GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .INIT_LEN(5),
    .INIT_X(16), .INIT_Y(30), .CELL_SHIFT(CS)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .START(START), .STEP(STEP), .DIR(DIR),
    .APPLE_X(APPLE_X), .APPLE_Y(APPLE_Y), .ADDRH(ADDRH), .ADDRV(ADDRV),
    .PIX_HEAD(PIX_HEAD), .PIX_BODY(PIX_BODY), .HEAD_X(HEAD_X), .HEAD_Y(HEAD_Y),
    .LENGTH(LENGTH), .BUSY(BUSY), .STEP_DONE(STEP_DONE), .HIT_APPLE(HIT_APPLE),
    .SUICIDE(SUICIDE), .WALL_HIT(WALL_HIT), .ALIVE(ALIVE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int due; int hx; int hy; int len; int hit; int sui; int wall; int alive;
  } step_exp_t;
  typedef struct { int due; int h; int b; } pix_exp_t;

  step_exp_t sq[$];
  pix_exp_t  rq[$];

  // Reference model: the body as a list of cells, head first.
  int mbx[$], mby[$];
  int mlen, mdir;
  bit mgrow, msui, mwall, malive;

  function automatic int dxf(input int d);
    return (d == 0) ? 1 : (d == 3) ? -1 : 0;
  endfunction
  function automatic int dyf(input int d);
    return (d == 1) ? 1 : (d == 2) ? -1 : 0;
  endfunction

  task automatic model_reset();
    mbx.delete(); mby.delete();
    for (int i = 0; i < 5; i++) begin mbx.push_back(16); mby.push_back(30 - i); end
    mlen = 5; mdir = 1; mgrow = 0; msui = 0; mwall = 0; malive = 1;
  endtask

  task automatic model_next(input int d, output int nx, output int ny, output bit oog,
                            output int ed);
    ed = (dxf(d) + dxf(mdir) == 0 && dyf(d) + dyf(mdir) == 0) ? mdir : d;
    nx = mbx[0] + dxf(ed);
    ny = mby[0] + dyf(ed);
    oog = 0;
`ifdef SNAKE_WRAP_EN
    nx = (nx + GW) % GW;
    ny = (ny + GH) % GH;
`else
    oog = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
`endif
  endtask

  task automatic model_step(input int issue, input int d, input int ax, input int ay);
    int nx, ny, ed, j;
    bit oog, hit;
    step_exp_t e;
    if (!malive) return;
    model_next(d, nx, ny, oog, ed);
    mdir = ed;
    if (oog) begin
      mwall = 1; malive = 0; mgrow = 0;
      e = '{issue + 2, mbx[0], mby[0], mlen, 0, 0, 1, 0};
      sq.push_back(e);
      return;
    end
    mbx.push_front(nx); mby.push_front(ny);
    if (mgrow && mlen < ML) mlen++;
    mgrow = 0;
    while (mbx.size() > mlen) begin void'(mbx.pop_back()); void'(mby.pop_back()); end
    j = 0;
    for (int i = 1; i < mlen; i++) if (j == 0 && mbx[i] == nx && mby[i] == ny) j = i;
    if (j != 0) begin msui = 1; malive = 0; end
    hit = (j == 0) && (nx == ax) && (ny == ay);
    if (hit) mgrow = 1;
    e = '{(j != 0) ? issue + 2 + j : issue + mlen + 1, nx, ny, mlen, int'(hit),
          int'(msui), 0, int'(malive)};
    sq.push_back(e);
  endtask

  task automatic exp_pix(input int ah, input int av, output int eh, output int eb);
    int cx, cy;
    cx = ah >> CS; cy = av >> CS;
    eh = 0; eb = 0;
    if (cx >= GW || cy >= GH) return;
    eh = (cx == mbx[0] && cy == mby[0]) ? 1 : 0;
    for (int i = 1; i < mlen; i++) if (mbx[i] == cx && mby[i] == cy) eb = 1;
    if (eh != 0) eb = 0;
  endtask

  // Monitor: pops and compares whenever the DUT reports a completed step or a pixel is due.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (STEP_DONE) begin
        if (sq.size() == 0) begin
          check("spurious_step_done", 1, 0);
        end else begin
          step_exp_t e;
          e = sq.pop_front();
          check("done_cycle", cyc, e.due);
          check("head_x", int'(HEAD_X), e.hx);
          check("head_y", int'(HEAD_Y), e.hy);
          check("length", int'(LENGTH), e.len);
          check("hit_apple", int'(HIT_APPLE), e.hit);
          check("suicide", int'(SUICIDE), e.sui);
          check("wall_hit", int'(WALL_HIT), e.wall);
          check("alive", int'(ALIVE), e.alive);
        end
      end else begin
        check("hit_apple_idle", int'(HIT_APPLE), 0);
      end
      if (sq.size() > 0 && sq[0].due < cyc) begin
        check("step_done_missing", 0, 1);
        void'(sq.pop_front());
      end
      while (rq.size() > 0 && rq[0].due <= cyc) begin
        pix_exp_t p;
        p = rq.pop_front();
        check("pix_head", int'(PIX_HEAD), p.h);
        check("pix_body", int'(PIX_BODY), p.b);
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (sq.size() > 0 && t < 200) begin @(posedge CLK); t++; end
    #1;
    if (sq.size() > 0) begin
      check("step_timeout", 0, 1);
      sq.delete();
    end
  endtask

  task automatic do_step(input int d, input int ax, input int ay, input bit extra);
    @(posedge CLK); #1;
    DIR = 2'(d); APPLE_X = XW'(ax); APPLE_Y = YW'(ay); STEP = 1'b1;
    model_step(cyc, d, ax, ay);
    @(posedge CLK); #1;
    STEP = extra;  // lands in MOVE: must be dropped
    @(posedge CLK); #1;
    STEP = 1'b0;
    wait_idle();
  endtask

  task automatic start_pulse(input bit with_step);
    @(posedge CLK); #1;
    START = 1'b1; STEP = with_step; DIR = 2'd0;
    sq.delete();
    model_reset();
    @(posedge CLK); #1;
    START = 1'b0; STEP = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic pix_at(input int ah, input int av);
    int eh, eb;
    pix_exp_t p;
    @(posedge CLK); #1;
    ADDRH = 10'(ah); ADDRV = 9'(av);
    exp_pix(ah, av, eh, eb);
    p = '{cyc + 1, eh, eb};
    rq.push_back(p);
  endtask

  task automatic render_burst(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        int i;
        i = $urandom_range(0, mlen - 1);
        pix_at(mbx[i] * 8 + $urandom_range(0, 7), mby[i] * 8 + $urandom_range(0, 7));
      end else begin
        pix_at($urandom_range(0, 1023), $urandom_range(0, 511));
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_head_x"}, int'(HEAD_X), 16);
    check({tag, "_head_y"}, int'(HEAD_Y), 30);
    check({tag, "_length"}, int'(LENGTH), 5);
    check({tag, "_alive"}, int'(ALIVE), 1);
    check({tag, "_busy"}, int'(BUSY), 0);
    check({tag, "_suicide"}, int'(SUICIDE), 0);
    check({tag, "_wall"}, int'(WALL_HIT), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (4) @(posedge CLK);
    #1 RESETN = 1'b1;
    repeat (100) @(posedge CLK);
    #1;
    check_reset_state("reset");
    check("reset_step_done", int'(STEP_DONE), 0);
    check("reset_hit", int'(HIT_APPLE), 0);
    check("reset_pix_head", int'(PIX_HEAD), 0);
    check("reset_pix_body", int'(PIX_BODY), 0);
    mon_en = 1'b1;

    // Initial body drawing, including tail, below-tail and off-grid pixels.
    pix_at(16 * 8 + 3, 30 * 8 + 5);
    pix_at(16 * 8, 26 * 8 + 7);
    pix_at(16 * 8, 25 * 8);
    pix_at(700, 100);
    render_burst(10);

    // Plain step right.
    do_step(0, 0, 0, 1'b0);
    check("plain_head_x", int'(HEAD_X), 17);
    check("plain_head_y", int'(HEAD_Y), 30);
    pix_at(136, 240);
    pix_at(16 * 8, 26 * 8);
    @(posedge CLK); #1;
    check("plain_pix_head_136_240", int'(PIX_HEAD), 0);  // last pixel was the old tail
    render_burst(6);

    // Apple growth, then saturation at MAX_LEN.
    do_step(0, 18, 30, 1'b1);
    do_step(0, 0, 0, 1'b0);
    check("grow_length", int'(LENGTH), 6);
    do_step(0, 20, 30, 1'b0);
    do_step(0, 0, 0, 1'b0);
    check("saturated_length", int'(LENGTH), 6);
    render_burst(8);

    // Reversal rejected while heading down.
    start_pulse(1'b0);
    check_reset_state("start");
    do_step(2, 0, 0, 1'b0);
    check("reversal_head_x", int'(HEAD_X), 16);
    check("reversal_head_y", int'(HEAD_Y), 31);

    // Self-collision, ignored steps afterwards, START recovery.
    start_pulse(1'b0);
    do_step(0, 0, 0, 1'b0);
    do_step(2, 0, 0, 1'b0);
    do_step(3, 0, 0, 1'b0);
    check("collide_suicide", int'(SUICIDE), 1);
    check("collide_alive", int'(ALIVE), 0);
    do_step(1, 0, 0, 1'b0);
    do_step(0, 0, 0, 1'b0);
    check("dead_head_x", int'(HEAD_X), 16);
    check("dead_head_y", int'(HEAD_Y), 29);
    render_burst(6);
    start_pulse(1'b1);  // START beats a simultaneous STEP
    repeat (10) @(posedge CLK);
    #1;
    check_reset_state("recover");

    // START mid-step aborts the step.
    @(posedge CLK); #1;
    DIR = 2'd0; STEP = 1'b1;
    model_step(cyc, 0, 0, 0);
    @(posedge CLK); #1;
    STEP = 1'b0;
    @(posedge CLK); #1;
    START = 1'b1;
    sq.delete();
    model_reset();
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    check_reset_state("abort");

    // Grid edge.
    for (int i = 0; i < 63; i++) do_step(0, 0, 0, 1'b0);
    check("edge_head_x", int'(HEAD_X), 79);
    do_step(0, 0, 0, 1'b0);
`ifdef SNAKE_WRAP_EN
    check("wrap_head_x", int'(HEAD_X), 0);
    check("wrap_wall", int'(WALL_HIT), 0);
`else
    check("wall_head_x", int'(HEAD_X), 79);
    check("wall_hit", int'(WALL_HIT), 1);
    check("wall_alive", int'(ALIVE), 0);
`endif
    render_burst(6);

    // Randomised play.
    start_pulse(1'b0);
    for (int it = 0; it < 250; it++) begin
      int d, ax, ay, nx, ny, ed;
      bit oog;
      if (!malive) start_pulse(1'($urandom_range(0, 1)));
      d = $urandom_range(0, 3);
      model_next(d, nx, ny, oog, ed);
      if ($urandom_range(0, 2) == 0 && !oog) begin ax = nx; ay = ny; end
      else begin ax = $urandom_range(0, GW - 1); ay = $urandom_range(0, GH - 1); end
      do_step(d, ax, ay, 1'($urandom_range(0, 1)));
      if ((it % 4) == 0) render_burst(6);
    end

    repeat (5) @(posedge CLK);
    #1;
    check("queue_drained", sq.size() + rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
